// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues one-cycle reads to a 16x8 registered RAM,
// captures the byte and holds it until accepted. Optional macro FETCH_COUNT_EN adds fetch_count.
module fetch_unit #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       jump_en,
    input  logic [3:0] jump_addr,
    input  logic       instr_ready,
    output logic       instr_valid,
    output logic [7:0] instr,
    output logic [3:0] instr_addr,
    output logic [3:0] mem_address,
    output logic       mem_rd,
    output logic       mem_we,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out
`ifdef FETCH_COUNT_EN
    ,
    output logic [7:0] fetch_count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] iaddr_q, iaddr_d;
    logic [7:0] instr_q, instr_d;
    logic       rd_q, rd_d;
    logic       valid_q, valid_d;
    logic       armed_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            iaddr_q <= 4'h0;
            instr_q <= 8'h00;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            iaddr_q <= iaddr_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        iaddr_d = iaddr_q;
        case (state_q)
            IDLE: begin
                if (jump_en)
                    pc_d = jump_addr;
                else if (start && armed_q)
                    state_d = ISSUE;
            end
            ISSUE: begin
                // A jump while the read strobe is up leaves a one-cycle bubble in ISSUE
                // so the re-issue never follows a strobe back to back.
                if (jump_en)
                    pc_d = jump_addr;
                else if (rd_q)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                if (jump_en) begin
                    pc_d    = jump_addr;
                    state_d = ISSUE;
                end else begin
                    instr_d = mem_data_out;
                    iaddr_d = pc_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (jump_en) begin
                    pc_d    = jump_addr;
                    state_d = ISSUE;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 4'd1;
                    state_d = start ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rd_d    = (state_d == ISSUE) && !rd_q;
        addr_d  = rd_d ? pc_d : addr_q;
        valid_d = (state_d == HOLD);
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_addr  = iaddr_q;
    assign mem_address = addr_q;
    assign mem_rd      = rd_q;
    assign mem_we      = 1'b0;
    assign mem_data_in = 8'h00;

`ifdef FETCH_COUNT_EN
    logic [7:0] count_q;

    // Jump together with ready still retires the held instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count_q <= 8'h00;
        else if (state_q == HOLD && instr_ready && count_q != 8'hFF)
            count_q <= count_q + 8'd1;
    end

    assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered 16x8 RAM model and an
// expected-instruction queue popped whenever an instruction is accepted.
module tb_fetch_unit;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       jump_en = 1'b0;
    logic [3:0] jump_addr = 4'h0;
    logic       instr_ready = 1'b1;
    logic       instr_valid;
    logic [7:0] instr;
    logic [3:0] instr_addr;
    logic [3:0] mem_address;
    logic       mem_rd;
    logic       mem_we;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out = 8'h00;
`ifdef FETCH_COUNT_EN
    logic [7:0] fetch_count;
`endif

    fetch_unit #(.RESET_PC(4'h0)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .jump_en(jump_en),
        .jump_addr(jump_addr), .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instr(instr), .instr_addr(instr_addr), .mem_address(mem_address),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
`ifdef FETCH_COUNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    always #5 clock = ~clock;

    logic [7:0] mem [16];
    always @(posedge clock) if (mem_rd) mem_data_out <= mem[mem_address];

    typedef struct packed { logic [3:0] a; logic [7:0] d; } exp_t;
    exp_t       exp_q[$];
    int         rd_cyc[$];
    logic [3:0] rd_addr[$];
    int         errors = 0, checks = 0, cyc_n = 0, pops = 0;
    bit         prev_rd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] a);
        exp_q.push_back('{a: a, d: mem[a]});
    endtask

    // One clock: monitor at the falling edge, return just after the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clock);
        if (mem_rd) begin
            chk("rd_back_to_back", 32'(prev_rd), 32'd0);
            rd_cyc.push_back(cyc_n);
            rd_addr.push_back(mem_address);
        end
        prev_rd = mem_rd;
        if (mem_we !== 1'b0 || mem_data_in !== 8'h00)
            chk("write_port_const", {23'd0, mem_we, mem_data_in}, 32'd0);
        if (instr_valid && instr_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("instr", 32'(instr), 32'(e.d));
                chk("instr_addr", 32'(instr_addr), 32'(e.a));
            end
            pops++;
        end
        cyc_n++;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_pops(input int n, input string tag);
        int t = 0;
        while (pops < n && t < 40) begin cyc(); t++; end
        chk(tag, 32'(pops), 32'(n));
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (instr_valid !== 1'b1 && t < 20) begin cyc(); t++; end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        int r, n, base;
        for (int i = 0; i < 16; i++) mem[i] = {i[3:0], 4'h5};
        mem[0] = 8'hAA;
        mem[1] = 8'h0F;

        // Reset values while reset_n is held low
        #1;
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_addr", 32'(instr_addr), 32'd0);
`ifdef FETCH_COUNT_EN
        chk("rst_fetch_count", 32'(fetch_count), 32'd0);
`endif

        // Streaming fetch of 0 and 1
        start = 1'b1;
        instr_ready = 1'b1;
        push(4'h0);
        push(4'h1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        r = cyc_n;
        wait_pops(2, "first_two_pops");
        chk("first_issue_delay", 32'((rd_cyc[0] - r) >= 2), 32'd1);
        chk("rd_period", 32'(rd_cyc[1] - rd_cyc[0]), 32'd3);
        chk("rd_addr0", 32'(rd_addr[0]), 32'h0);
        chk("rd_addr1", 32'(rd_addr[1]), 32'h1);

        // Backpressure on the fetch of address 2
        instr_ready = 1'b0;
        push(4'h2);
        wait_valid("hold_valid");
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("hold_valid_stable", 32'(instr_valid), 32'd1);
            chk("hold_instr_stable", 32'(instr), 32'h25);
            chk("hold_addr_stable", 32'(instr_addr), 32'h2);
            chk("hold_no_rd", 32'(mem_rd), 32'd0);
        end
        instr_ready = 1'b1;
        start = 1'b0;
        n = pops;
        wait_pops(n + 1, "accept_held");

        // Jump while idle, then wrap from 4'hF to 4'h0
        cyc();
        jump_en = 1'b1;
        jump_addr = 4'hF;
        cyc();
        jump_en = 1'b0;
        cyc();
        chk("idle_jump_no_rd", 32'(mem_rd), 32'd0);
        chk("idle_jump_no_valid", 32'(instr_valid), 32'd0);
        base = rd_addr.size();
        start = 1'b1;
        push(4'hF);
        push(4'h0);
        wait_pops(n + 3, "wrap_pops");
        chk("wrap_rd_F", 32'(rd_addr[base]), 32'hF);
        chk("wrap_rd_0", 32'(rd_addr[base + 1]), 32'h0);

        // Jump during CAPTURE of address 1: captured byte dropped
        cyc();
        chk("capture_src_addr", 32'(rd_addr[rd_addr.size() - 1]), 32'h1);
        jump_en = 1'b1;
        jump_addr = 4'h3;
        base = rd_addr.size();
        push(4'h3);
        cyc();
        jump_en = 1'b0;
        wait_pops(n + 4, "capture_jump_pop");
        chk("capture_jump_rd", 32'(rd_addr[base]), 32'h3);

        // Jump and ready together in HOLD
        instr_ready = 1'b0;
        push(4'h4);
        wait_valid("hold4_valid");
        instr_ready = 1'b1;
        jump_en = 1'b1;
        jump_addr = 4'h2;
        base = rd_addr.size();
        cyc();
        jump_en = 1'b0;
        push(4'h2);
        wait_pops(n + 6, "hold_jump_pops");
        chk("hold_jump_rd", 32'(rd_addr[base]), 32'h2);
`ifdef FETCH_COUNT_EN
        chk("fetch_count_total", 32'(fetch_count), 32'(pops));
`endif

        // Reset asserted while a read is in flight
        for (int t = 0; t < 10 && mem_rd !== 1'b1; t++) cyc();
        chk("reset_in_issue_setup", 32'(mem_rd), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_rd", 32'(mem_rd), 32'd0);
        chk("reset_mid_valid", 32'(instr_valid), 32'd0);
        chk("reset_mid_addr", 32'(mem_address), 32'h0);
        exp_q.delete();
        start = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("no_valid_after_reset", 32'(instr_valid), 32'd0);
        end
        n = pops;
        start = 1'b1;
        push(4'h0);
        wait_pops(n + 1, "post_reset_fetch");
`ifdef FETCH_COUNT_EN
        chk("fetch_count_after_reset", 32'(fetch_count), 32'd1);
`endif
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
